// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring)
// engine; one bit per clock, 64-bit result {hi, lo} loaded on completion.
module mul_div_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic        r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [32:0] r_mq;
  logic [63:0] r_result;
  logic        r_dbz;

  logic        w_accept;
  logic        w_is_dbz;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_booth_acc;
  logic [32:0] w_trial;
  logic [63:0] w_div_acc;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_dbz = op && (b == 32'h0);
  assign w_abs_a  = a[31] ? -a : a;
  assign w_abs_b  = b[31] ? -b : b;

  // Booth pair {b[i], b[i-1]}: 01 adds the shifted multiplicand, 10 subtracts it.
  always_comb begin
    w_booth_acc = r_acc;
    case (r_mq[1:0])
      2'b01:   w_booth_acc = r_acc + r_mcand;
      2'b10:   w_booth_acc = r_acc - r_mcand;
      default: w_booth_acc = r_acc;
    endcase
  end

  // Divide packs {remainder, quotient/dividend-shift} into r_acc; divisor sits in r_mcand[31:0].
  assign w_trial   = r_acc[63:31] - {1'b0, r_mcand[31:0]};
  assign w_div_acc = w_trial[32] ? {r_acc[62:0], 1'b0}
                                 : {w_trial[31:0], r_acc[30:0], 1'b1};

  assign w_quo = r_neg_q ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_next = w_is_dbz ? S_DONE : S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN:   if (r_cnt == 5'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt    <= 5'd0;
      r_op     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= 64'h0;
      r_mcand  <= 64'h0;
      r_mq     <= 33'h0;
      r_result <= 64'h0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op  <= op;
            r_cnt <= 5'd0;
            if (w_is_dbz) begin
              r_result <= {a, 32'hFFFF_FFFF};
              r_dbz    <= 1'b1;
            end else if (op) begin
              r_acc   <= {32'h0, w_abs_a};
              r_mcand <= {32'h0, w_abs_b};
              r_neg_q <= a[31] ^ b[31];
              r_neg_r <= a[31];
            end else begin
              r_acc   <= 64'h0;
              r_mcand <= {{32{a[31]}}, a};
              r_mq    <= {b, 1'b0};
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc   <= w_booth_acc;
            r_mcand <= {r_mcand[62:0], 1'b0};
            r_mq    <= {r_mq[32], r_mq[32:1]};
          end
        end
        S_FIX: begin
          r_result <= r_op ? {w_rem, w_quo} : r_acc;
          r_dbz    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign dbz    = r_dbz;
  assign result = r_result;

endmodule
